// File: rtl/dmem_resp_if.sv
// rtl/dmem_resp_if.sv - M-stage memory request/response bundle between pipeline and data memory
interface dmem_resp_if;
    logic        mem_write_m;
    logic        mem_to_reg_m;
    logic [31:0] alu_out_m;
    logic [31:0] write_data_m;
    logic [31:0] read_data_m;
    logic        stall_m;
    logic        addr_err;
    logic [31:0] err_addr;
    logic        err_valid;

    modport master (
        output mem_write_m, mem_to_reg_m, alu_out_m, write_data_m,
        input  read_data_m, stall_m, addr_err, err_addr, err_valid
    );

    modport slave (
        input  mem_write_m, mem_to_reg_m, alu_out_m, write_data_m,
        output read_data_m, stall_m, addr_err, err_addr, err_valid
    );
endinterface

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - fixed-latency word RAM responder that stalls the pipeline while an access is in flight
module dmem_resp #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h10010000
) (
    input  logic        clk,
    input  logic        rst_n,
    dmem_resp_if.slave  bus
);
    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        data_q, data_d;
    logic               we_q, we_d;
    logic               rd_q, rd_d;
    logic [31:0]        read_data_q, read_data_d;
    logic [31:0]        err_addr_q, err_addr_d;
    logic               err_valid_q, err_valid_d;

    logic [31:0]        mem [DEPTH_WORDS];

    logic               req, legal, take, illegal, commit;
    logic [31:0]        offset;

    assign req     = bus.mem_write_m | bus.mem_to_reg_m;
    assign offset  = bus.alu_out_m - BASE_ADDR;
    assign legal   = (bus.alu_out_m[1:0] == 2'b00) && (bus.alu_out_m >= BASE_ADDR)
                     && ({1'b0, offset} < SPAN);
    assign take    = (state_q == S_IDLE) && req && legal;
    assign illegal = (state_q == S_IDLE) && req && !legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            read_data_q <= '0;
            err_addr_q  <= '0;
            err_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            read_data_q <= read_data_d;
            err_addr_q  <= err_addr_d;
            err_valid_q <= err_valid_d;
        end
    end

    // The IDLE cycle itself is the first stall cycle, so BUSY lasts LATENCY-1 cycles.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        data_d      = data_q;
        we_d        = we_q;
        rd_d        = rd_q;
        err_addr_d  = err_addr_q;
        err_valid_d = err_valid_q;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    idx_d   = offset[IDX_W+1:2];
                    data_d  = bus.write_data_m;
                    we_d    = bus.mem_write_m;
                    rd_d    = bus.mem_to_reg_m;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY > 1) ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (illegal && !err_valid_q) begin
            err_addr_d  = bus.alu_out_m;
            err_valid_d = 1'b1;
        end
    end

    // The _d copies hold the live request when committing straight from IDLE.
    always_comb begin
        commit      = (state_d == S_DONE) && (state_q != S_DONE);
        read_data_d = read_data_q;
        if (commit && rd_d)
            read_data_d = mem[idx_d];
    end

    always_ff @(posedge clk) begin
        if (rst_n && commit && we_d)
            mem[idx_d] <= data_d;
    end

    always_comb begin
        bus.stall_m     = take || (state_q == S_BUSY);
        bus.addr_err    = illegal;
        bus.read_data_m = read_data_q;
        bus.err_addr    = err_addr_q;
        bus.err_valid   = err_valid_q;
    end
endmodule
